oflow_mem_ctrl: RTL and testbench
=================================

Name: oflow_mem_ctrl

Overview:
Controller and arbiter for the 284-bit dual-port bbox feature memory, an array of 256x64 DPRAM macros with active-low csb/web/oeb.
- Shares the memory between the feature-extraction writer and the similarity-metric reader. The writer stores two rows per beat on ports 0 and 1; the reader reads one row per beat on port 0.
- Manages ping-pong frame banks on the address MSB: the current frame is written while the previous frame is read.
- Generates all memory strobes, addresses and the read-valid pipeline.

Parameters:
DATA_WIDTH_MEM, 284, row width (two bboxes, 142 bits each)
ADDR_WIDTH, 8, memory address width; MSB selects the bank
READ_LATENCY, 1, cycles from the memory strobe edge to mem_data_out_0 being valid (1..3)

Ports:
clk  in  1  clock
reset_N  in  1  asynchronous reset, active-high (1 = reset), despite the _N suffix
wr_req  in  1  writer beat valid
wr_data_0  in  DATA_WIDTH_MEM  row at even offset
wr_data_1  in  DATA_WIDTH_MEM  row at odd offset
wr_single  in  1  beat carries only wr_data_0
wr_last  in  1  last beat of the frame
wr_ack  out  1  beat accepted (combinational)
wr_full  out  1  write bank full
wr_ovf  out  1  sticky: data was discarded this frame
rd_req  in  1  reader request
rd_addr  in  ADDR_WIDTH-1  row index within the read bank
rd_ack  out  1  request accepted (combinational)
rd_valid  out  1  read data valid
rd_data  out  DATA_WIDTH_MEM  read row
rd_err  out  1  with rd_valid: row index out of range
rd_frame_done  in  1  reader has finished the current bank (pulse)
rd_row_count  out  ADDR_WIDTH  rows available in the read bank
rd_bank_valid  out  1  read bank holds a complete frame
mem_address_0, mem_address_1  out  ADDR_WIDTH  port addresses
mem_data_in_0, mem_data_in_1  out  DATA_WIDTH_MEM  write data
mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1, mem_web_1, mem_oeb_1  out  1  active-low strobes
mem_data_out_0  in  DATA_WIDTH_MEM  port-0 read data

Behaviour:
- Reset values: all mem_csb/web/oeb = 1; addresses and data = 0; wr_ack, rd_ack, rd_valid, rd_err, wr_full, wr_ovf, rd_bank_valid = 0; rd_row_count = 0; wbank = 0; wr_rows = 0.
- Reset mid-operation drops in-flight reads; no rd_valid is issued for them.
- Memory outputs are registered. An accepted beat in cycle t drives strobes in cycle t+1; every other cycle all strobes are 1.
- Write beat: mem_address_0 = {wbank, wr_rows}; mem_address_1 = {wbank, wr_rows+1}; both web and csb = 0.
  - With wr_single, port 1 stays idle (csb_1 = 1).
  - wr_rows advances by 2, or by 1 with wr_single.
- Read: mem_address_0 = {~wbank, rd_addr}; csb_0 = 0, web_0 = 1, oeb_0 = 0.
  - rd_valid is asserted in cycle t+1+READ_LATENCY.
  - rd_data equals mem_data_out_0 when rd_valid = 1, else 0.
- Reads are accepted only when rd_bank_valid = 1.
  - If rd_addr >= rd_row_count: acked, no strobe, rd_valid at the same latency with rd_data = 0 and rd_err = 1.
- Arbitration: port 0 is shared.
  - When an acceptable write and read both request, grant alternates; the side not granted last time wins.
  - The last-grant register resets to "read", so write wins the first conflict.
  - An uncontested request is always granted.
- Full: wr_full = 1 when wr_rows + (wr_single ? 1 : 2) > 2^(ADDR_WIDTH-1).
  - A full non-last beat is not acked.
  - A full beat with wr_last is acked, its data is discarded (no strobes), and wr_ovf is set.
- Frame FSM:
  - FILL: writes are accepted. An accepted wr_last moves to WAIT_SWAP.
  - WAIT_SWAP: wr_ack = 0. Swap when (rd_frame_done has been seen OR rd_bank_valid = 0) AND the read pipeline is empty.
  - Swap (single cycle, back to FILL): wbank toggles; rd_row_count <= wr_rows; wr_rows <= 0; rd_bank_valid <= 1; wr_ovf and the sticky done flag clear.
- rd_frame_done is latched sticky, so an early pulse during FILL counts.
- rd_frame_done in the same cycle as a read request: the read is still served; the swap waits for its rd_valid.

Optional Feature:
OFLOW_MEM_CTRL_STATS_EN
- Defined: adds outputs stat_wr_beats, stat_rd_beats and stat_conflicts (16-bit each).
  - Each counter saturates at 0xFFFF.
  - All counters clear on reset and on swap.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package oflow_mem_ctrl_pkg:
  - frame_state_t {FILL, WAIT_SWAP}
  - grant_t {GNT_RD, GNT_WR}
  - BANK_ROWS = 2^(ADDR_WIDTH-1)
  - default strobe-idle constant
- Sub-module oflow_mem_rr_arbiter: 2-requester round-robin arbiter with a last-grant register.

Test Plan:
- Write 3 beats (pairs), then a single beat with wr_last:
  - strobes at addrs 0/1, 2/3, 4/5, then 6 only (csb_1 = 1);
  - after a reader done pulse, swap gives rd_row_count = 7 and wbank = 1.
- Read rd_addr = 5 with READ_LATENCY = 1, ack in cycle t:
  - mem_address_0 = 0x05 in t+1;
  - rd_valid in t+2 with the stored row.
- Read rd_addr = 9 with rd_row_count = 7: no strobe; rd_valid with rd_err = 1 and rd_data = 0.
- wr_req and rd_req held together for 4 cycles: grants are W, R, W, R; stat_conflicts = 4 when stats are enabled.
- Fill 128 rows, then a non-last beat: wr_full = 1, no ack. A following wr_last beat: acked, no strobes, wr_ovf = 1.
- Assert reset_N = 1 with a read in flight: all strobes = 1 immediately, rd_valid never asserts, rd_bank_valid = 0.

Source files
------------

// File: rtl/oflow_mem_ctrl_pkg.sv
// Shared types and constants for the bbox feature-memory controller.
package oflow_mem_ctrl_pkg;

    typedef enum logic {FILL, WAIT_SWAP} frame_state_t;
    typedef enum logic {GNT_RD, GNT_WR} grant_t;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned BANK_ROWS = 2 ** (DEF_ADDR_WIDTH - 1);

    // Active-low macro strobes for one port.
    typedef struct packed {
        logic csb;
        logic web;
        logic oeb;
    } mem_strobe_t;

    localparam mem_strobe_t STROBE_IDLE  = '{csb: 1'b1, web: 1'b1, oeb: 1'b1};
    localparam mem_strobe_t STROBE_WRITE = '{csb: 1'b0, web: 1'b0, oeb: 1'b1};
    localparam mem_strobe_t STROBE_READ  = '{csb: 1'b0, web: 1'b1, oeb: 1'b0};

    function automatic int unsigned bank_rows(input int unsigned aw);
        return 1 << (aw - 1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/oflow_mem_rr_arbiter.sv
// Two-requester round-robin arbiter; on a conflict the side not granted last time wins.
module oflow_mem_rr_arbiter
    import oflow_mem_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset_N,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);

    grant_t last_q;

    always_comb begin
        gnt_wr = req_wr && (!req_rd || (last_q == GNT_RD));
        gnt_rd = req_rd && !gnt_wr;
    end

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            last_q <= GNT_RD;
        end else if (gnt_wr) begin
            last_q <= GNT_WR;
        end else if (gnt_rd) begin
            last_q <= GNT_RD;
        end
    end

endmodule

// File: rtl/oflow_mem_ctrl.sv
// Ping-pong frame-bank controller/arbiter for the dual-port bbox feature memory.
// Optional activity counters: define OFLOW_MEM_CTRL_STATS_EN.
module oflow_mem_ctrl
    import oflow_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH_MEM = 284,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned READ_LATENCY   = 1
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic                      wr_req,
    input  logic [DATA_WIDTH_MEM-1:0] wr_data_0,
    input  logic [DATA_WIDTH_MEM-1:0] wr_data_1,
    input  logic                      wr_single,
    input  logic                      wr_last,
    output logic                      wr_ack,
    output logic                      wr_full,
    output logic                      wr_ovf,
    input  logic                      rd_req,
    input  logic [ADDR_WIDTH-2:0]     rd_addr,
    output logic                      rd_ack,
    output logic                      rd_valid,
    output logic [DATA_WIDTH_MEM-1:0] rd_data,
    output logic                      rd_err,
    input  logic                      rd_frame_done,
    output logic [ADDR_WIDTH-1:0]     rd_row_count,
    output logic                      rd_bank_valid,
    output logic [ADDR_WIDTH-1:0]     mem_address_0,
    output logic [ADDR_WIDTH-1:0]     mem_address_1,
    output logic [DATA_WIDTH_MEM-1:0] mem_data_in_0,
    output logic [DATA_WIDTH_MEM-1:0] mem_data_in_1,
    output logic                      mem_csb_0,
    output logic                      mem_web_0,
    output logic                      mem_oeb_0,
    output logic                      mem_csb_1,
    output logic                      mem_web_1,
    output logic                      mem_oeb_1,
    input  logic [DATA_WIDTH_MEM-1:0] mem_data_out_0
`ifdef OFLOW_MEM_CTRL_STATS_EN
    ,
    output logic [15:0]               stat_wr_beats,
    output logic [15:0]               stat_rd_beats,
    output logic [15:0]               stat_conflicts
`endif
);

    localparam int unsigned RA   = ADDR_WIDTH - 1;
    localparam int unsigned ROWS = bank_rows(ADDR_WIDTH);

    frame_state_t state_q, state_d;
    logic wbank_q, done_q, bank_valid_q, ovf_q;
    logic [ADDR_WIDTH-1:0] wr_rows_q, rows_avail_q, row_next;
    logic [ADDR_WIDTH:0] wr_inc, wr_need;
    logic [READ_LATENCY:0] vpipe_q, epipe_q;
    logic wr_ok, rd_ok, gnt_wr, gnt_rd, rd_hit, swap;
    mem_strobe_t stb0_q, stb1_q;

    assign wr_inc   = wr_single ? (ADDR_WIDTH+1)'(1) : (ADDR_WIDTH+1)'(2);
    assign wr_need  = {1'b0, wr_rows_q} + wr_inc;
    assign wr_full  = wr_need > (ADDR_WIDTH+1)'(ROWS);
    assign row_next = wr_rows_q + ADDR_WIDTH'(1);
    assign rd_hit   = {1'b0, rd_addr} < rows_avail_q;

    // A full beat is still acceptable when it closes the frame; its data is dropped.
    assign wr_ok = !reset_N && (state_q == FILL) && wr_req && (!wr_full || wr_last);
    assign rd_ok = rd_req && bank_valid_q;

    oflow_mem_rr_arbiter u_arb (
        .clk     (clk),
        .reset_N (reset_N),
        .req_wr  (wr_ok),
        .req_rd  (rd_ok),
        .gnt_wr  (gnt_wr),
        .gnt_rd  (gnt_rd)
    );

    // A read granted this cycle targets the current read bank, so it blocks the swap.
    assign swap = (state_q == WAIT_SWAP) && (done_q || rd_frame_done || !bank_valid_q)
                  && (vpipe_q == '0) && !gnt_rd;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:      if (gnt_wr && wr_last) state_d = WAIT_SWAP;
            WAIT_SWAP: if (swap) state_d = FILL;
            default:   state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            stb0_q        <= STROBE_IDLE;
            stb1_q        <= STROBE_IDLE;
            mem_address_0 <= '0;
            mem_address_1 <= '0;
            mem_data_in_0 <= '0;
            mem_data_in_1 <= '0;
            vpipe_q       <= '0;
            epipe_q       <= '0;
            wbank_q       <= 1'b0;
            wr_rows_q     <= '0;
            rows_avail_q  <= '0;
            bank_valid_q  <= 1'b0;
            ovf_q         <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            stb0_q  <= STROBE_IDLE;
            stb1_q  <= STROBE_IDLE;
            vpipe_q <= {vpipe_q[READ_LATENCY-1:0], gnt_rd};
            epipe_q <= {epipe_q[READ_LATENCY-1:0], gnt_rd && !rd_hit};
            if (rd_frame_done) done_q <= 1'b1;
            if (gnt_wr) begin
                if (wr_full) begin
                    ovf_q <= 1'b1;
                end else begin
                    stb0_q        <= STROBE_WRITE;
                    stb1_q        <= wr_single ? STROBE_IDLE : STROBE_WRITE;
                    mem_address_0 <= {wbank_q, wr_rows_q[RA-1:0]};
                    mem_address_1 <= {wbank_q, row_next[RA-1:0]};
                    mem_data_in_0 <= wr_data_0;
                    mem_data_in_1 <= wr_data_1;
                    wr_rows_q     <= wr_rows_q + wr_inc[ADDR_WIDTH-1:0];
                end
            end else if (gnt_rd && rd_hit) begin
                stb0_q        <= STROBE_READ;
                mem_address_0 <= {~wbank_q, rd_addr};
            end
            if (swap) begin
                wbank_q      <= ~wbank_q;
                rows_avail_q <= wr_rows_q;
                wr_rows_q    <= '0;
                bank_valid_q <= 1'b1;
                ovf_q        <= 1'b0;
                done_q       <= 1'b0;
            end
        end
    end

    assign wr_ack        = gnt_wr;
    assign rd_ack        = gnt_rd;
    assign wr_ovf        = ovf_q;
    assign rd_row_count  = rows_avail_q;
    assign rd_bank_valid = bank_valid_q;
    assign rd_valid      = vpipe_q[READ_LATENCY];
    assign rd_err        = epipe_q[READ_LATENCY];
    assign rd_data       = (rd_valid && !rd_err) ? mem_data_out_0 : '0;
    assign mem_csb_0     = stb0_q.csb;
    assign mem_web_0     = stb0_q.web;
    assign mem_oeb_0     = stb0_q.oeb;
    assign mem_csb_1     = stb1_q.csb;
    assign mem_web_1     = stb1_q.web;
    assign mem_oeb_1     = stb1_q.oeb;

`ifdef OFLOW_MEM_CTRL_STATS_EN
    logic [15:0] st_wr_q, st_rd_q, st_cf_q;

    always_ff @(posedge clk or posedge reset_N) begin
        if (reset_N) begin
            st_wr_q <= '0;
            st_rd_q <= '0;
            st_cf_q <= '0;
        end else if (swap) begin
            st_wr_q <= '0;
            st_rd_q <= '0;
            st_cf_q <= '0;
        end else begin
            if (gnt_wr) st_wr_q <= sat_inc16(st_wr_q);
            if (gnt_rd) st_rd_q <= sat_inc16(st_rd_q);
            if (wr_ok && rd_ok) st_cf_q <= sat_inc16(st_cf_q);
        end
    end

    assign stat_wr_beats  = st_wr_q;
    assign stat_rd_beats  = st_rd_q;
    assign stat_conflicts = st_cf_q;
`endif

endmodule

// File: tb/tb_oflow_mem_ctrl.sv
// Directed bench for oflow_mem_ctrl with a behavioural DPRAM (READ_LATENCY = 1).
module tb_oflow_mem_ctrl;

    localparam int DW = 284;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_N, wr_req, wr_single, wr_last, rd_req, rd_frame_done;
    logic [DW-1:0] wr_data_0, wr_data_1, rd_data, mem_data_in_0, mem_data_in_1;
    logic [AW-2:0] rd_addr;
    logic wr_ack, wr_full, wr_ovf, rd_ack, rd_valid, rd_err, rd_bank_valid;
    logic [AW-1:0] rd_row_count, mem_address_0, mem_address_1;
    logic mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1, mem_web_1, mem_oeb_1;
    logic [DW-1:0] mem_data_out_0;
`ifdef OFLOW_MEM_CTRL_STATS_EN
    logic [15:0] stat_wr_beats, stat_rd_beats, stat_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    oflow_mem_ctrl dut (
        .clk            (clk),
        .reset_N        (reset_N),
        .wr_req         (wr_req),
        .wr_data_0      (wr_data_0),
        .wr_data_1      (wr_data_1),
        .wr_single      (wr_single),
        .wr_last        (wr_last),
        .wr_ack         (wr_ack),
        .wr_full        (wr_full),
        .wr_ovf         (wr_ovf),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ack         (rd_ack),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .rd_err         (rd_err),
        .rd_frame_done  (rd_frame_done),
        .rd_row_count   (rd_row_count),
        .rd_bank_valid  (rd_bank_valid),
        .mem_address_0  (mem_address_0),
        .mem_address_1  (mem_address_1),
        .mem_data_in_0  (mem_data_in_0),
        .mem_data_in_1  (mem_data_in_1),
        .mem_csb_0      (mem_csb_0),
        .mem_web_0      (mem_web_0),
        .mem_oeb_0      (mem_oeb_0),
        .mem_csb_1      (mem_csb_1),
        .mem_web_1      (mem_web_1),
        .mem_oeb_1      (mem_oeb_1),
        .mem_data_out_0 (mem_data_out_0)
`ifdef OFLOW_MEM_CTRL_STATS_EN
        ,
        .stat_wr_beats  (stat_wr_beats),
        .stat_rd_beats  (stat_rd_beats),
        .stat_conflicts (stat_conflicts)
`endif
    );

    // Behavioural DPRAM: one-cycle registered read on port 0.
    logic [DW-1:0] mem [0:255];
    logic [DW-1:0] mem_q = '0;
    always @(posedge clk) begin
        if (!mem_csb_0 && !mem_web_0) mem[mem_address_0] <= mem_data_in_0;
        if (!mem_csb_0 && mem_web_0 && !mem_oeb_0) mem_q <= mem[mem_address_0];
        if (!mem_csb_1 && !mem_web_1) mem[mem_address_1] <= mem_data_in_1;
    end
    assign mem_data_out_0 = mem_q;

    function automatic logic [DW-1:0] pat(input int k);
        logic [31:0] w;
        w = 32'hC0DE0000 | 32'(k);
        return {w[27:0], {8{w}}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_req = 0; wr_single = 0; wr_last = 0; rd_req = 0; rd_frame_done = 0;
        rd_addr = '0; wr_data_0 = '0; wr_data_1 = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset_N = 1;
        wr_req = 1;
        rd_req = 1;
        tick(); tick();
        checks++;
        if ({mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1, mem_web_1, mem_oeb_1} !== 6'h3F) begin
            errors++; $display("FAIL reset_strobes: got %b want 111111",
                {mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1, mem_web_1, mem_oeb_1});
        end
        checks++;
        if ({mem_address_0, mem_address_1} !== 16'h0 || mem_data_in_0 !== '0) begin
            errors++; $display("FAIL reset_addr_data: got %h/%h", mem_address_0, mem_address_1);
        end
        checks++;
        if ({wr_ack, rd_ack, rd_valid, rd_err, wr_full, wr_ovf, rd_bank_valid} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000",
                {wr_ack, rd_ack, rd_valid, rd_err, wr_full, wr_ovf, rd_bank_valid});
        end
        checks++;
        if (rd_row_count !== 8'd0) begin
            errors++; $display("FAIL reset_row_count: got %0d want 0", rd_row_count);
        end
        idle_inputs();
        reset_N = 0;
        tick();
    endtask

    task automatic test_write_frame();
        for (int b = 0; b < 4; b++) begin
            wr_req = 1; wr_single = (b == 3); wr_last = (b == 3);
            wr_data_0 = pat(2 * b); wr_data_1 = pat(2 * b + 1);
            #1;
            checks++;
            if (wr_ack !== 1'b1) begin
                errors++; $display("FAIL wr_ack_beat%0d: got %b want 1", b, wr_ack);
            end
            tick();
            checks++;
            if ({mem_csb_0, mem_web_0, mem_csb_1, mem_web_1} !== ((b == 3) ? 4'b0011 : 4'b0000))
            begin
                errors++; $display("FAIL wr_strobes_beat%0d: got %b", b,
                    {mem_csb_0, mem_web_0, mem_csb_1, mem_web_1});
            end
            checks++;
            if (mem_address_0 !== 8'(2 * b) || mem_data_in_0 !== pat(2 * b)) begin
                errors++; $display("FAIL wr_addr0_beat%0d: got %h want %h", b, mem_address_0,
                    8'(2 * b));
            end
            if (b < 3) begin
                checks++;
                if (mem_address_1 !== 8'(2 * b + 1)) begin
                    errors++; $display("FAIL wr_addr1_beat%0d: got %h want %h", b,
                        mem_address_1, 8'(2 * b + 1));
                end
            end
        end
        wr_single = 0; wr_last = 0; rd_frame_done = 1;
        #1;
        checks++;
        if (wr_ack !== 1'b0) begin
            errors++; $display("FAIL wr_ack_wait_swap: got %b want 0", wr_ack);
        end
        wr_req = 0;
        tick();
        rd_frame_done = 0;
        checks++;
        if (mem_csb_0 !== 1'b1 || rd_row_count !== 8'd7 || rd_bank_valid !== 1'b1) begin
            errors++; $display("FAIL swap1: csb0=%b rows=%0d bv=%b want 1/7/1", mem_csb_0,
                rd_row_count, rd_bank_valid);
        end
    endtask

    task automatic test_read();
        rd_req = 1; rd_addr = 7'd5;
        #1;
        checks++;
        if (rd_ack !== 1'b1) begin
            errors++; $display("FAIL rd_ack: got %b want 1", rd_ack);
        end
        tick();
        rd_req = 0;
        checks++;
        if (mem_address_0 !== 8'h05 || {mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1} !== 4'b0101)
        begin
            errors++; $display("FAIL rd_strobe: addr=%h stb=%b want 05/0101", mem_address_0,
                {mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1});
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL rd_valid_early: got %b want 0", rd_valid);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_err !== 1'b0 || rd_data !== pat(5)) begin
            errors++; $display("FAIL rd_data5: valid=%b err=%b data=%h", rd_valid, rd_err,
                rd_data);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0 || rd_data !== '0) begin
            errors++; $display("FAIL rd_valid_drop: got %b want 0", rd_valid);
        end
    endtask

    task automatic test_read_oor();
        rd_req = 1; rd_addr = 7'd9;
        #1;
        checks++;
        if (rd_ack !== 1'b1) begin
            errors++; $display("FAIL oor_ack: got %b want 1", rd_ack);
        end
        tick();
        rd_req = 0;
        checks++;
        if (mem_csb_0 !== 1'b1) begin
            errors++; $display("FAIL oor_no_strobe: csb0=%b want 1", mem_csb_0);
        end
        tick();
        checks++;
        if ({rd_valid, rd_err} !== 2'b11 || rd_data !== '0) begin
            errors++; $display("FAIL oor_err: valid/err=%b data=%h want 11/0", {rd_valid, rd_err},
                rd_data);
        end
        tick();
    endtask

    task automatic test_conflict();
        for (int c = 0; c < 4; c++) begin
            logic w;
            w = (c % 2 == 0);
            wr_req = 1; wr_data_0 = pat(100 + c); wr_data_1 = pat(101 + c);
            rd_req = 1; rd_addr = 7'd2;
            #1;
            checks++;
            if ({wr_ack, rd_ack} !== {w, !w}) begin
                errors++; $display("FAIL conflict_gnt%0d: got wr/rd=%b want %b", c,
                    {wr_ack, rd_ack}, {w, !w});
            end
            tick();
            checks++;
            if (mem_address_0 !== (w ? 8'(8'h80 + c) : 8'h02)) begin
                errors++; $display("FAIL conflict_addr%0d: got %h want %h", c, mem_address_0,
                    w ? 8'(8'h80 + c) : 8'h02);
            end
            if (c == 2) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== pat(2)) begin
                    errors++; $display("FAIL conflict_rd: valid=%b data=%h", rd_valid, rd_data);
                end
            end
        end
        wr_req = 0; rd_req = 0;
        tick(); tick(); tick();
`ifdef OFLOW_MEM_CTRL_STATS_EN
        checks++;
        if (stat_conflicts !== 16'd4 || stat_wr_beats !== 16'd2 || stat_rd_beats !== 16'd4) begin
            errors++; $display("FAIL stats: cf=%0d wr=%0d rd=%0d want 4/2/4", stat_conflicts,
                stat_wr_beats, stat_rd_beats);
        end
`endif
    endtask

    task automatic test_full();
        // Bank 1 holds 4 rows; 62 more pairs bring it to exactly 128.
        for (int b = 0; b < 62; b++) begin
            wr_req = 1; wr_data_0 = pat(200 + 2 * b); wr_data_1 = pat(201 + 2 * b);
            #1;
            checks++;
            if (wr_ack !== 1'b1 || wr_full !== 1'b0) begin
                errors++; $display("FAIL fill_beat%0d: ack=%b full=%b want 1/0", b, wr_ack,
                    wr_full);
            end
            tick();
        end
        #1;
        checks++;
        if (wr_full !== 1'b1 || wr_ack !== 1'b0) begin
            errors++; $display("FAIL full_nolast: full=%b ack=%b want 1/0", wr_full, wr_ack);
        end
        tick();
        checks++;
        if ({mem_csb_0, mem_csb_1, wr_ovf} !== 3'b110) begin
            errors++; $display("FAIL full_idle: csb0/csb1/ovf=%b want 110",
                {mem_csb_0, mem_csb_1, wr_ovf});
        end
        wr_last = 1;
        #1;
        checks++;
        if (wr_ack !== 1'b1) begin
            errors++; $display("FAIL full_last_ack: got %b want 1", wr_ack);
        end
        tick();
        wr_req = 0; wr_last = 0;
        checks++;
        if ({mem_csb_0, mem_csb_1, wr_ovf} !== 3'b111) begin
            errors++; $display("FAIL full_last_drop: csb0/csb1/ovf=%b want 111",
                {mem_csb_0, mem_csb_1, wr_ovf});
        end
    endtask

    task automatic test_swap_done();
        tick(); tick(); tick();
        checks++;
        if (rd_row_count !== 8'd7 || wr_ovf !== 1'b1) begin
            errors++; $display("FAIL swap_hold: rows=%0d ovf=%b want 7/1", rd_row_count, wr_ovf);
        end
        rd_frame_done = 1; rd_req = 1; rd_addr = 7'd3;
        #1;
        checks++;
        if (rd_ack !== 1'b1) begin
            errors++; $display("FAIL done_rd_ack: got %b want 1", rd_ack);
        end
        tick();
        rd_frame_done = 0; rd_req = 0;
        tick();
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== pat(3) || rd_row_count !== 8'd7) begin
            errors++; $display("FAIL done_rd_data: valid=%b rows=%0d data=%h", rd_valid,
                rd_row_count, rd_data);
        end
        tick();
        checks++;
        if (rd_row_count !== 8'd7) begin
            errors++; $display("FAIL swap_early: rows=%0d want 7", rd_row_count);
        end
        tick();
        checks++;
        if (rd_row_count !== 8'd128 || wr_ovf !== 1'b0 || rd_bank_valid !== 1'b1) begin
            errors++; $display("FAIL swap2: rows=%0d ovf=%b bv=%b want 128/0/1", rd_row_count,
                wr_ovf, rd_bank_valid);
        end
`ifdef OFLOW_MEM_CTRL_STATS_EN
        checks++;
        if ({stat_wr_beats, stat_rd_beats, stat_conflicts} !== 48'h0) begin
            errors++; $display("FAIL stats_clear: wr=%0d rd=%0d cf=%0d want 0", stat_wr_beats,
                stat_rd_beats, stat_conflicts);
        end
`endif
        wr_req = 1; wr_data_0 = pat(300); wr_data_1 = pat(301);
        tick();
        wr_req = 0;
        checks++;
        if (mem_address_0 !== 8'h00 || mem_address_1 !== 8'h01 || mem_csb_0 !== 1'b0) begin
            errors++; $display("FAIL bank0_write: addr=%h/%h csb0=%b want 00/01/0",
                mem_address_0, mem_address_1, mem_csb_0);
        end
    endtask

    task automatic test_reset_inflight();
        rd_req = 1; rd_addr = 7'd4;
        #1;
        checks++;
        if (rd_ack !== 1'b1) begin
            errors++; $display("FAIL flight_ack: got %b want 1", rd_ack);
        end
        tick();
        rd_req = 0;
        reset_N = 1;
        #1;
        checks++;
        if ({mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1, mem_web_1, mem_oeb_1} !== 6'h3F ||
            rd_bank_valid !== 1'b0) begin
            errors++; $display("FAIL flight_reset: strobes=%b bv=%b want 111111/0",
                {mem_csb_0, mem_web_0, mem_oeb_0, mem_csb_1, mem_web_1, mem_oeb_1},
                rd_bank_valid);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 2) reset_N = 0;
            tick();
            checks++;
            if (rd_valid !== 1'b0) begin
                errors++; $display("FAIL flight_valid%0d: got %b want 0", i, rd_valid);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_frame();
        test_read();
        test_read_oor();
        test_conflict();
        test_full();
        test_swap_done();
        test_reset_inflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
